// File: rtl/wb_result_buffer_pkg.sv
// Shared types for the writeback result buffer.
// XLEN and exception_t mirror the core's riscv/ariane definitions so this slice builds on its own.
package wb_result_buffer_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned WB_NR_ENTRIES = 8;
    localparam int unsigned WB_NR_PORTS   = 4;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic            alloc;
        logic            done;
        logic [XLEN-1:0] result;
        exception_t      exception;
    } wb_slot_t;

    // The lower index wins when two ports target the same slot.
    typedef enum logic [1:0] {
        PORT_FLU   = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_STORE = 2'd2,
        PORT_FPU   = 2'd3
    } wb_port_e;

endpackage

// File: rtl/wb_port_select.sv
// Combinational merge of the execute-stage writeback ports into one write per slot,
// using the fixed priority flu > load > store > fpu.
module wb_port_select
    import wb_result_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = WB_NR_ENTRIES,
    parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic [WB_NR_PORTS-1:0]   valid_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i  [WB_NR_PORTS],
    input  logic [XLEN-1:0]          result_i    [WB_NR_PORTS],
    input  exception_t               exception_i [WB_NR_PORTS],
    output logic [NR_ENTRIES-1:0]    we_o,
    output logic [XLEN-1:0]          result_o    [NR_ENTRIES],
    output exception_t               exception_o [NR_ENTRIES]
);

    // Ports are scanned lowest priority first so the highest-priority hit is applied last.
    always_comb begin
        for (int s = 0; s < NR_ENTRIES; s++) begin
            we_o[s]        = 1'b0;
            result_o[s]    = '0;
            exception_o[s] = '0;
            for (int p = WB_NR_PORTS - 1; p >= 0; p--) begin
                if (valid_i[p] && (trans_id_i[p] == TRANS_ID_BITS'(s))) begin
                    we_o[s]        = 1'b1;
                    result_o[s]    = result_i[p];
                    exception_o[s] = exception_i[p];
                end
            end
        end
    end

endmodule

// File: rtl/wb_result_buffer.sv
// Writeback result buffer: in-order slot allocation at issue, out-of-order writeback by trans_id,
// in-order retirement to commit. Optional forwarding lookup enabled by defining WB_FORWARD_EN.
module wb_result_buffer
    import wb_result_buffer_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = WB_NR_ENTRIES,
    parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    input  logic                     flu_valid_i,
    input  logic [TRANS_ID_BITS-1:0] flu_trans_id_i,
    input  logic [XLEN-1:0]          flu_result_i,
    input  exception_t               flu_exception_i,
    input  logic                     load_valid_i,
    input  logic [TRANS_ID_BITS-1:0] load_trans_id_i,
    input  logic [XLEN-1:0]          load_result_i,
    input  exception_t               load_exception_i,
    input  logic                     store_valid_i,
    input  logic [TRANS_ID_BITS-1:0] store_trans_id_i,
    input  logic [XLEN-1:0]          store_result_i,
    input  exception_t               store_exception_i,
    input  logic                     fpu_valid_i,
    input  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i,
    input  logic [XLEN-1:0]          fpu_result_i,
    input  exception_t               fpu_exception_i,
    output logic                     commit_valid_o,
    output logic [TRANS_ID_BITS-1:0] commit_trans_id_o,
    output logic [XLEN-1:0]          commit_result_o,
    output exception_t               commit_exception_o,
    input  logic                     commit_ack_i
`ifdef WB_FORWARD_EN
    ,
    input  logic [TRANS_ID_BITS-1:0] fwd_trans_id_i,
    output logic                     fwd_valid_o,
    output logic [XLEN-1:0]          fwd_result_o
`endif
);

    localparam int unsigned           CNT_BITS   = TRANS_ID_BITS + 1;
    localparam logic [CNT_BITS-1:0]   FULL_COUNT = CNT_BITS'(NR_ENTRIES);

    logic [NR_ENTRIES-1:0]    alloc_q, alloc_d, done_q, done_d;
    logic [XLEN-1:0]          result_q    [NR_ENTRIES];
    exception_t               exception_q [NR_ENTRIES];
    logic [TRANS_ID_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]      count_q, count_d;

    logic [WB_NR_PORTS-1:0]   portValid;
    logic [TRANS_ID_BITS-1:0] portId        [WB_NR_PORTS];
    logic [XLEN-1:0]          portResult    [WB_NR_PORTS];
    exception_t               portException [WB_NR_PORTS];
    logic [NR_ENTRIES-1:0]    selWe, wbWe;
    logic [XLEN-1:0]          selResult     [NR_ENTRIES];
    exception_t               selException  [NR_ENTRIES];

    logic     issueFire, commitFire;
    wb_slot_t headSlot;

    assign portValid                 = {fpu_valid_i, store_valid_i, load_valid_i, flu_valid_i};
    assign portId[PORT_FLU]          = flu_trans_id_i;
    assign portId[PORT_LOAD]         = load_trans_id_i;
    assign portId[PORT_STORE]        = store_trans_id_i;
    assign portId[PORT_FPU]          = fpu_trans_id_i;
    assign portResult[PORT_FLU]      = flu_result_i;
    assign portResult[PORT_LOAD]     = load_result_i;
    assign portResult[PORT_STORE]    = store_result_i;
    assign portResult[PORT_FPU]      = fpu_result_i;
    assign portException[PORT_FLU]   = flu_exception_i;
    assign portException[PORT_LOAD]  = load_exception_i;
    assign portException[PORT_STORE] = store_exception_i;
    assign portException[PORT_FPU]   = fpu_exception_i;

    wb_port_select #(
        .NR_ENTRIES    (NR_ENTRIES),
        .TRANS_ID_BITS (TRANS_ID_BITS)
    ) i_port_select (
        .valid_i     (portValid),
        .trans_id_i  (portId),
        .result_i    (portResult),
        .exception_i (portException),
        .we_o        (selWe),
        .result_o    (selResult),
        .exception_o (selException)
    );

    // Writebacks to slots that are not allocated are dropped here.
    assign wbWe = selWe & alloc_q;

    assign headSlot = '{alloc:     alloc_q[head_q],
                        done:      done_q[head_q],
                        result:    result_q[head_q],
                        exception: exception_q[head_q]};

    assign issue_ready_o      = (count_q != FULL_COUNT);
    assign issue_trans_id_o   = tail_q;
    assign commit_valid_o     = headSlot.alloc && headSlot.done;
    assign commit_trans_id_o  = head_q;
    assign commit_result_o    = headSlot.result;
    assign commit_exception_o = headSlot.exception;

    assign issueFire  = issue_valid_i && issue_ready_o;
    assign commitFire = commit_ack_i && commit_valid_o;

    // Issue and commit never touch the same slot: that needs full or empty, which blocks one side.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q | wbWe;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commitFire) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + TRANS_ID_BITS'(1);
        end
        if (issueFire) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + TRANS_ID_BITS'(1);
        end
        case ({issueFire, commitFire})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; alloc/done qualify it.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NR_ENTRIES; s++) begin
            if (wbWe[s]) begin
                result_q[s]    <= selResult[s];
                exception_q[s] <= selException[s];
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid_o  = alloc_q[fwd_trans_id_i] && done_q[fwd_trans_id_i];
    assign fwd_result_o = result_q[fwd_trans_id_i];
`endif

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed self-checking bench for wb_result_buffer (8 slots); forwarding checks build with WB_FORWARD_EN.
module tb_wb_result_buffer;
    import wb_result_buffer_pkg::*;

    localparam int unsigned IDW = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i, issue_valid_i, issue_ready_o, commit_ack_i, commit_valid_o;
    logic [IDW-1:0]   issue_trans_id_o, commit_trans_id_o;
    logic             flu_valid_i, load_valid_i, store_valid_i, fpu_valid_i;
    logic [IDW-1:0]   flu_trans_id_i, load_trans_id_i, store_trans_id_i, fpu_trans_id_i;
    logic [XLEN-1:0]  flu_result_i, load_result_i, store_result_i, fpu_result_i, commit_result_o;
    exception_t       flu_exception_i, load_exception_i, store_exception_i, fpu_exception_i;
    exception_t       commit_exception_o;
`ifdef WB_FORWARD_EN
    logic [IDW-1:0]   fwd_trans_id_i;
    logic             fwd_valid_o;
    logic [XLEN-1:0]  fwd_result_o;
`endif

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk_i = ~clk_i;

    wb_result_buffer #(.NR_ENTRIES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
        .flu_valid_i(flu_valid_i), .flu_trans_id_i(flu_trans_id_i),
        .flu_result_i(flu_result_i), .flu_exception_i(flu_exception_i),
        .load_valid_i(load_valid_i), .load_trans_id_i(load_trans_id_i),
        .load_result_i(load_result_i), .load_exception_i(load_exception_i),
        .store_valid_i(store_valid_i), .store_trans_id_i(store_trans_id_i),
        .store_result_i(store_result_i), .store_exception_i(store_exception_i),
        .fpu_valid_i(fpu_valid_i), .fpu_trans_id_i(fpu_trans_id_i),
        .fpu_result_i(fpu_result_i), .fpu_exception_i(fpu_exception_i),
        .commit_valid_o(commit_valid_o), .commit_trans_id_o(commit_trans_id_o),
        .commit_result_o(commit_result_o), .commit_exception_o(commit_exception_o),
        .commit_ack_i(commit_ack_i)
`ifdef WB_FORWARD_EN
        ,
        .fwd_trans_id_i(fwd_trans_id_i), .fwd_valid_o(fwd_valid_o), .fwd_result_o(fwd_result_o)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        flush_i = 1'b0; issue_valid_i = 1'b0; commit_ack_i = 1'b0;
        flu_valid_i = 1'b0; load_valid_i = 1'b0; store_valid_i = 1'b0; fpu_valid_i = 1'b0;
        flu_trans_id_i = '0; load_trans_id_i = '0; store_trans_id_i = '0; fpu_trans_id_i = '0;
        flu_result_i = '0; load_result_i = '0; store_result_i = '0; fpu_result_i = '0;
        flu_exception_i = '0; load_exception_i = '0; store_exception_i = '0; fpu_exception_i = '0;
    endtask

    // Drives the currently set inputs through one rising edge, then clears them.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
        clearInputs();
    endtask

    task automatic setPort(input int port, input logic [IDW-1:0] id, input logic [XLEN-1:0] data,
                           input logic excValid);
        exception_t exc;
        exc = '{cause: data, tval: data, valid: excValid};
        case (port)
            0: begin flu_valid_i = 1'b1;   flu_trans_id_i = id;   flu_result_i = data;   flu_exception_i = exc;   end
            1: begin load_valid_i = 1'b1;  load_trans_id_i = id;  load_result_i = data;  load_exception_i = exc;  end
            2: begin store_valid_i = 1'b1; store_trans_id_i = id; store_result_i = data; store_exception_i = exc; end
            default: begin fpu_valid_i = 1'b1; fpu_trans_id_i = id; fpu_result_i = data; fpu_exception_i = exc; end
        endcase
    endtask

    task automatic doReset();
        clearInputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
`ifdef WB_FORWARD_EN
        fwd_trans_id_i = 3'd4;
`endif
        doReset();
        checkOutput("rstReady", issue_ready_o, 1);
        checkOutput("rstIssueId", issue_trans_id_o, 0);
        checkOutput("rstCommitValid", commit_valid_o, 0);
        checkOutput("rstCommitId", commit_trans_id_o, 0);
`ifdef WB_FORWARD_EN
        checkOutput("rstFwdValid", fwd_valid_o, 0);
`endif

        // In-order commit of out-of-order writebacks.
        for (int i = 0; i < 3; i++) begin
            checkOutput("issueId", issue_trans_id_o, 64'(i));
            issue_valid_i = 1'b1;
            applyStimulus();
        end
        setPort(3, 3'd2, 64'h33, 1'b0);
        applyStimulus();
        checkOutput("headNotDone", commit_valid_o, 0);
        setPort(1, 3'd0, 64'h11, 1'b0);
        checkOutput("noBypass", commit_valid_o, 0);
        applyStimulus();
        checkOutput("c0Valid", commit_valid_o, 1);
        checkOutput("c0Id", commit_trans_id_o, 0);
        checkOutput("c0Result", commit_result_o, 64'h11);
        setPort(0, 3'd1, 64'h22, 1'b0);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("c1Id", commit_trans_id_o, 1);
        checkOutput("c1Result", commit_result_o, 64'h22);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("c2Id", commit_trans_id_o, 2);
        checkOutput("c2Result", commit_result_o, 64'h33);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("emptyValid", commit_valid_o, 0);
        checkOutput("emptyHead", commit_trans_id_o, 3);

        // Full buffer, free-on-ack and tail wrap-around.
        doReset();
        for (int i = 0; i < 8; i++) begin
            checkOutput("fillReady", issue_ready_o, 1);
            issue_valid_i = 1'b1;
            applyStimulus();
        end
        checkOutput("fullReady", issue_ready_o, 0);
        issue_valid_i = 1'b1;
        applyStimulus();
        checkOutput("fullIgnoreIssue", issue_ready_o, 0);
        setPort(0, 3'd0, 64'h55, 1'b0);
        applyStimulus();
        checkOutput("fullHeadValid", commit_valid_o, 1);
        commit_ack_i = 1'b1;
        checkOutput("readyNoAckPath", issue_ready_o, 0);
        applyStimulus();
        checkOutput("readyAfterAck", issue_ready_o, 1);
        checkOutput("wrapIssueId", issue_trans_id_o, 0);
        issue_valid_i = 1'b1;
        applyStimulus();
        checkOutput("wrapFull", issue_ready_o, 0);
        checkOutput("wrapTail", issue_trans_id_o, 1);
        checkOutput("wrapHead", commit_trans_id_o, 1);

        // Port priority on a shared id and store-then-exception overwrite.
        setPort(0, 3'd3, 64'hA, 1'b0);
        setPort(1, 3'd3, 64'hB, 1'b0);
        setPort(2, 3'd1, 64'hC, 1'b0);
        applyStimulus();
        checkOutput("storeResult", commit_result_o, 64'hC);
        checkOutput("storeExc", commit_exception_o.valid, 0);
        setPort(1, 3'd1, 64'hD, 1'b1);
        setPort(3, 3'd2, 64'h2D, 1'b0);
        applyStimulus();
        checkOutput("excResult", commit_result_o, 64'hD);
        checkOutput("excValid", commit_exception_o.valid, 1);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("id2Result", commit_result_o, 64'h2D);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("prioId", commit_trans_id_o, 3);
        checkOutput("prioResult", commit_result_o, 64'hA);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("id4NotDone", commit_valid_o, 0);

        // Five slots allocated (4,5,6,7,0), two done, then flush with issue and ack.
        setPort(3, 3'd4, 64'h40, 1'b0);
        setPort(2, 3'd5, 64'h50, 1'b0);
        applyStimulus();
        checkOutput("preFlushValid", commit_valid_o, 1);
        checkOutput("preFlushResult", commit_result_o, 64'h40);
        flush_i = 1'b1; issue_valid_i = 1'b1; commit_ack_i = 1'b1;
        setPort(0, 3'd6, 64'h60, 1'b0);
        applyStimulus();
        checkOutput("flushReady", issue_ready_o, 1);
        checkOutput("flushIssueId", issue_trans_id_o, 0);
        checkOutput("flushCommitValid", commit_valid_o, 0);
        checkOutput("flushCommitId", commit_trans_id_o, 0);
`ifdef WB_FORWARD_EN
        checkOutput("flushFwdValid", fwd_valid_o, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            checkOutput("postFlushReady", issue_ready_o, 1);
            issue_valid_i = 1'b1;
            applyStimulus();
        end
        checkOutput("postFlushFull", issue_ready_o, 0);

        // Ack while nothing is committable must not move the head.
        commit_ack_i = 1'b1;
        applyStimulus();
        setPort(1, 3'd0, 64'h10, 1'b0);
        applyStimulus();
        checkOutput("ignoredAckValid", commit_valid_o, 1);
        checkOutput("ignoredAckId", commit_trans_id_o, 0);
        checkOutput("ignoredAckResult", commit_result_o, 64'h10);

        setPort(0, 3'd4, 64'h44, 1'b0);
`ifdef WB_FORWARD_EN
        checkOutput("fwdSameCycle", fwd_valid_o, 0);
`endif
        applyStimulus();
`ifdef WB_FORWARD_EN
        checkOutput("fwdNextValid", fwd_valid_o, 1);
        checkOutput("fwdNextResult", fwd_result_o, 64'h44);
`endif
        setPort(0, 3'd1, 64'h21, 1'b0);
        setPort(1, 3'd2, 64'h22, 1'b0);
        setPort(2, 3'd3, 64'h23, 1'b0);
        applyStimulus();
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("drain1Id", commit_trans_id_o, 1);
        checkOutput("drain1Result", commit_result_o, 64'h21);
        checkOutput("drain1Ready", issue_ready_o, 1);
        // Issue and commit together: count holds at 7, both pointers step.
        issue_valid_i = 1'b1; commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("bothTail", issue_trans_id_o, 1);
        checkOutput("bothReady", issue_ready_o, 1);
        checkOutput("bothResult", commit_result_o, 64'h22);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("drain3Result", commit_result_o, 64'h23);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("drain4Id", commit_trans_id_o, 4);
        checkOutput("drain4Result", commit_result_o, 64'h44);
        commit_ack_i = 1'b1;
        applyStimulus();
        checkOutput("drain5Valid", commit_valid_o, 0);
        checkOutput("drain5Id", commit_trans_id_o, 5);
`ifdef WB_FORWARD_EN
        checkOutput("fwdAfterCommit", fwd_valid_o, 0);
`endif

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("asyncReady", issue_ready_o, 1);
        checkOutput("asyncIssueId", issue_trans_id_o, 0);
        checkOutput("asyncCommitValid", commit_valid_o, 0);
        checkOutput("asyncCommitId", commit_trans_id_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
